// File: rtl/piso_shift8b.sv
// 8-bit parallel-in/serial-out shifter with valid/ready input and per-bit hold of DIV cycles.
// Optional even-parity bit after bit 7 when PISO_PARITY_EN is defined.
module piso_shift8b #(
  parameter int DIV       = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic       clk,
  input  logic       res,
  input  logic       in_valid,
  input  logic [7:0] in,
  output logic       in_ready,
  output logic       sout,
  output logic       sout_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] div_q, div_d;
`ifdef PISO_PARITY_EN
  logic       par_q, par_d;
`endif

  logic bit_end;
  logic frame_end;
  logic accept;

  assign bit_end = (div_q == DIV_LAST);

`ifdef PISO_PARITY_EN
  assign frame_end = (state_q == PAR) && bit_end;
`else
  assign frame_end = (state_q == SHIFT) && bit_end && (bit_cnt_q == 4'd7);
`endif

  // in_ready depends only on registered state and reset, never on in_valid.
  assign in_ready = !res && ((state_q == IDLE) || frame_end);
  assign accept   = in_valid && in_ready;

  always_comb begin
    busy       = (state_q != IDLE);
    sout_valid = busy;
    done       = frame_end && !res;
    sout       = 1'b0;
    case (state_q)
      SHIFT:   sout = (MSB_FIRST != 0) ? shreg_q[7] : shreg_q[0];
`ifdef PISO_PARITY_EN
      PAR:     sout = par_q;
`endif
      default: sout = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
`ifdef PISO_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      SHIFT: begin
        if (bit_end) begin
          div_d     = 8'd0;
          shreg_d   = (MSB_FIRST != 0) ? {shreg_q[6:0], 1'b0} : {1'b0, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
`ifdef PISO_PARITY_EN
            state_d = PAR;
`else
            state_d = IDLE;
`endif
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
`ifdef PISO_PARITY_EN
      PAR: begin
        if (bit_end) begin
          div_d   = 8'd0;
          state_d = IDLE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
`endif
      default: ;
    endcase
    // Acceptance on the final cycle of a frame overrides the return to IDLE,
    // which is what makes back-to-back bytes gapless.
    if (accept) begin
      state_d   = SHIFT;
      shreg_d   = in;
      bit_cnt_d = 4'd0;
      div_d     = 8'd0;
`ifdef PISO_PARITY_EN
      par_d     = ^in;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= IDLE;
      shreg_q   <= 8'd0;
      bit_cnt_q <= 4'd0;
      div_q     <= 8'd0;
`ifdef PISO_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
`ifdef PISO_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_shift8b.sv
// Bench for piso_shift8b: two instances (DIV=1 LSB-first, DIV=3 MSB-first) against a
// queue-of-expected-cycles reference model; honours PISO_PARITY_EN.
module tb_piso_shift8b;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res;
  logic [1:0] vld;
  logic [7:0] din0, din1;
  logic [1:0] rdy, so, sv, bz, dn;

  piso_shift8b #(.DIV(1), .MSB_FIRST(0)) u_a (
    .clk(clk), .res(res), .in_valid(vld[0]), .in(din0), .in_ready(rdy[0]),
    .sout(so[0]), .sout_valid(sv[0]), .busy(bz[0]), .done(dn[0])
  );

  piso_shift8b #(.DIV(3), .MSB_FIRST(1)) u_b (
    .clk(clk), .res(res), .in_valid(vld[1]), .in(din1), .in_ready(rdy[1]),
    .sout(so[1]), .sout_valid(sv[1]), .busy(bz[1]), .done(dn[1])
  );

`ifdef PISO_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  int errs = 0;
  int checks = 0;

  // Each entry is one expected output cycle: {sout bit, last cycle of frame}.
  logic [1:0] qa[$];
  logic [1:0] qb[$];
  logic [1:0] acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? qa.size() : qb.size();
  endfunction

  function automatic logic [1:0] qfront(input int i);
    if (qsize(i) == 0) return 2'b00;
    return (i == 0) ? qa[0] : qb[0];
  endfunction

  task automatic qpush(input int i, input logic [1:0] v);
    if (i == 0) qa.push_back(v); else qb.push_back(v);
  endtask

  task automatic qpop(input int i);
    logic [1:0] d;
    if (i == 0) d = qa.pop_front(); else d = qb.pop_front();
  endtask

  task automatic qclear(input int i);
    if (i == 0) qa.delete(); else qb.delete();
  endtask

  task automatic push_frame(input int i, input logic [7:0] b);
    int  dv;
    logic bt;
    dv = (i == 0) ? 1 : 3;
    for (int k = 0; k < NB; k++) begin
      if (k == 8) bt = ^b;
      else if (i == 1) bt = b[7 - k];
      else bt = b[k];
      for (int r = 0; r < dv; r++)
        qpush(i, {bt, ((k == NB - 1) && (r == dv - 1))});
    end
  endtask

  // One clock: predict acceptance, advance model at the edge, compare at the falling edge.
  task automatic tick();
    logic       rs;
    logic [1:0] e;
    logic       ne;
    rs = res;
    for (int i = 0; i < 2; i++)
      acc[i] = vld[i] && !rs && (qsize(i) <= 1);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rs) qclear(i);
      else begin
        if (qsize(i) > 0) qpop(i);
        if (acc[i]) push_frame(i, (i == 0) ? din0 : din1);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      e  = qfront(i);
      ne = (qsize(i) > 0);
      chk($sformatf("sout%0d", i),       32'(so[i]),  32'(ne & e[1]));
      chk($sformatf("sout_valid%0d", i), 32'(sv[i]),  32'(ne));
      chk($sformatf("busy%0d", i),       32'(bz[i]),  32'(ne));
      chk($sformatf("done%0d", i),       32'(dn[i]),  32'(ne & e[0] & !res));
      chk($sformatf("in_ready%0d", i),   32'(rdy[i]), 32'(!res && (qsize(i) <= 1)));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((qsize(0) > 0 || qsize(1) > 0) && n < 200) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(n >= 200), 32'd0);
  endtask

  initial begin
    logic [7:0] got;
    int cntb, dna, idx0, idx1, n;

    res = 1'b1; vld = 2'b00; din0 = 8'h00; din1 = 8'h00;
    @(negedge clk);
    tick(); tick();
    res = 1'b0;
    tick();
    chk("rst_in_ready", 32'(rdy), 32'h3);
    chk("rst_sout_valid", 32'(sv), 32'h0);

    // A5 LSB-first DIV=1 on u_a, 81 MSB-first DIV=3 on u_b
    din0 = 8'hA5; din1 = 8'h81; vld = 2'b11;
    tick();
    vld = 2'b00; din0 = 8'h5A; din1 = 8'h7E;
    cntb = 0; dna = 0; got = 8'h00;
    for (int k = 0; k < 40; k++) begin
      if (k < 8) got[k] = so[0];
      if (bz[1]) cntb++;
      if (dn[0]) dna++;
      tick();
    end
    chk("a5_bits", 32'(got), 32'hA5);
    chk("b_busy_len", 32'(cntb), 32'(NB * 3));
    chk("a_done_cnt", 32'(dna), 32'd1);

    // Back-to-back FF then 00 with in_valid held high
    idx0 = 0; idx1 = 0; dna = 0; n = 0;
    din0 = 8'hFF; din1 = 8'hFF; vld = 2'b11;
    while (n < 200 && !(idx0 >= 2 && idx1 >= 2 && qsize(0) == 0 && qsize(1) == 0)) begin
      tick();
      n++;
      if (dn[0]) dna++;
      if (acc[0]) begin idx0++; if (idx0 >= 2) vld[0] = 1'b0; else din0 = 8'h00; end
      if (acc[1]) begin idx1++; if (idx1 >= 2) vld[1] = 1'b0; else din1 = 8'h00; end
    end
    chk("stream_timeout", 32'(n >= 200), 32'd0);
    chk("stream_done_cnt", 32'(dna), 32'd2);

    // Reset during the 4th bit of a 3C frame
    din0 = 8'h3C; din1 = 8'h3C; vld = 2'b11;
    tick();
    vld = 2'b00;
    tick(); tick(); tick();
    res = 1'b1;
    tick();
    res = 1'b0;
    chk("abort_sv", 32'(sv), 32'h0);
    chk("abort_done", 32'(dn), 32'h0);
    tick();
    chk("abort_ready", 32'(rdy), 32'h3);

    // Randomized traffic with occasional reset
    for (int k = 0; k < 800; k++) begin
      res  = ($urandom_range(0, 59) == 0);
      vld  = 2'($urandom);
      din0 = 8'($urandom);
      din1 = 8'($urandom);
      tick();
    end
    res = 1'b0; vld = 2'b00;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/piso_shift8b.md
# piso_shift8b

8-bit parallel-in/serial-out shifter for the sequential pipe. It sits directly downstream of the 8-bit parallel pipeline register. It accepts one byte per valid/ready handshake and shifts it out one bit at a time, holding each bit for a programmable number of cycles. Back-to-back bytes stream with no idle gap.

## Interface
- DIV, default 1: clock cycles each serial bit is held; legal range 1..255.
- MSB_FIRST, default 0: 0 = bit 0 shifted first; 1 = bit 7 shifted first.
- clk  input  1  system clock; all state changes on rising edge.
- res  input  1  reset; synchronous, active-high.
- in_valid  input  1  upstream byte on `in` is valid.
- in  input  8  parallel byte from the upstream register.
- in_ready  output  1  shifter can accept a byte this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  `sout` carries a frame bit.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse on the final cycle of the final bit of a frame.

## Operation
- FSM states:
  - IDLE: no frame.
  - SHIFT: data bits 0..7.
  - PAR: parity bit; exists only with the macro.
- Reset:
  - State → IDLE; shift register, bit counter and divider counter → 0.
  - Outputs after the reset edge: sout=0, sout_valid=0, busy=0, done=0, in_ready=1.
  - While res is high, in_ready is forced to 0 and no byte is accepted.
- Accept: a byte transfers when in_valid=1 and in_ready=1 at a rising edge.
  - The byte is loaded into the shift register, the bit counter → 0, the divider → 0, and the state → SHIFT.
- in_ready = (state==IDLE) or (final cycle of the final frame bit), and not res.
  - This is combinational from registered state.
  - in_valid must not feed in_ready; no combinational path in_valid→in_ready.
- SHIFT:
  - sout = current head bit: bit 0 side when MSB_FIRST=0, bit 7 side when MSB_FIRST=1.
  - sout_valid=1, busy=1.
  - The divider counts 0..DIV-1.
  - On DIV-1 the register shifts one place (vacated bit filled with 0), the divider → 0, and the bit counter increments.
  - After bit 7 completes: go to PAR if the macro is defined, else end the frame.
- Frame end:
  - done=1 for exactly one cycle, the final cycle of the final bit.
  - Next state: SHIFT if a new byte was accepted that same edge, else IDLE.
  - In IDLE: sout=0, sout_valid=0, busy=0.
- in_valid is ignored while in_ready=0; `in` is sampled only at acceptance.
  - Upstream may change `in` freely after the accepting edge.
- Reset mid-frame: the frame is aborted immediately; no done pulse; the partial byte is discarded.
- Counters:
  - Bit counter: 4 bits. Wraps only via reload on accept.
  - Divider: 8 bits. DIV=1 means the divider is always 0, so one cycle per bit.

## Timing
- Latency: the byte is accepted at edge N; its first bit is on sout during cycle N+1.
- Frame length: 8·DIV cycles, or 9·DIV with parity.
- Gapless streaming: with in_valid held high, frame k+1's first bit follows frame k's last bit on the very next cycle; sout_valid never drops.
- Single-byte frame with DIV=1: busy high for exactly 8 cycles (9 with parity); done in the 8th (9th).
- Throughput: 1 byte per 8·DIV cycles maximum (9·DIV with parity).

## Configuration
- PISO_PARITY_EN defined:
  - PAR state is present and appends one even-parity bit (XOR of the 8 accepted data bits) after bit 7, held DIV cycles, sout_valid=1.
  - done and in_ready move to the final cycle of the parity bit.
- PISO_PARITY_EN undefined:
  - PAR state and parity logic are absent.
  - The frame is exactly 8 data bits.

## Test plan
- Reset then idle:
  - Stimulus: res=1 for 2 cycles, then release.
  - Required: in_ready=1, sout=0, sout_valid=0, busy=0, done=0.
- Single byte, LSB first, DIV=1, no parity:
  - Stimulus: in=8'hA5, one handshake.
  - Required: sout = 1,0,1,0,0,1,0,1 on cycles N+1..N+8; done only at N+8; IDLE at N+9.
- MSB first with DIV=3:
  - Stimulus: MSB_FIRST=1, DIV=3, in=8'h81.
  - Required: sout = 1 for 3 cycles, 0 for 18 cycles, 1 for 3 cycles; busy high for 24 cycles.
- Back-to-back streaming:
  - Stimulus: in_valid held high with bytes 8'hFF then 8'h00.
  - Required: sout_valid continuously 1 for 16 cycles; sout = eight 1s then eight 0s; two done pulses 8 cycles apart.
- Reset mid-frame:
  - Stimulus: accept 8'h3C; assert res on the 4th bit cycle.
  - Required: next cycle sout_valid=0, busy=0; no done pulse; in_ready=1 after release.
- Parity build (PISO_PARITY_EN):
  - Stimulus: in=8'h07.
  - Required: 9th bit = 1, done on the 9th cycle.
  - Stimulus: in=8'h03.
  - Required: 9th bit = 0.
